// File: rtl/mips_control_fsm_pkg.sv
// Shared types for the multi-cycle MIPS control unit: state encoding, opcode/funct
// constants, ALU op classes and the per-state strobe table.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [1:0] {
        AOP_ADD   = 2'b00,
        AOP_SUB   = 2'b01,
        AOP_FUNCT = 2'b10
    } alu_op_t;

    localparam logic [2:0] ALUCTL_ADD = 3'b010;
    localparam logic [2:0] ALUCTL_SUB = 3'b110;
    localparam logic [2:0] ALUCTL_AND = 3'b000;
    localparam logic [2:0] ALUCTL_OR  = 3'b001;
    localparam logic [2:0] ALUCTL_SLT = 3'b111;

    typedef struct packed {
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       pc_write;
        logic       branch;
        logic       iord;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        alu_op_t    alu_op;
    } ctrl_t;

    // Moore strobe table; everything not named for a state stays 0 / ALU add.
    function automatic ctrl_t state_ctrl(input state_t s);
        ctrl_t c;
        c        = '0;
        c.alu_op = AOP_ADD;
        case (s)
            FETCH: begin
                c.alu_src_b = 2'b01;
                c.ir_write  = 1'b1;
                c.pc_write  = 1'b1;
            end
            DECODE:  c.alu_src_b = 2'b11;
            MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            MEMRD:   c.iord = 1'b1;
            MEMWB: begin
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
            end
            MEMWR: begin
                c.iord      = 1'b1;
                c.mem_write = 1'b1;
            end
            RTYPEEX: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = AOP_FUNCT;
            end
            RTYPEWB: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
            end
            BEQEX: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = AOP_SUB;
                c.pc_src    = 2'b01;
                c.branch    = 1'b1;
            end
            ADDIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            ADDIWB:  c.reg_write = 1'b1;
            JEX: begin
                c.pc_src   = 2'b10;
                c.pc_write = 1'b1;
            end
            default: c.alu_op = AOP_ADD;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mips_control_fsm_alu_decoder.sv
// ALU control decode: maps the FSM's ALU op class plus the funct field to the
// 3-bit ALU control word. Purely combinational.
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  alu_op_t    alu_op_i,
    input  logic [5:0] funct_i,
    output logic [2:0] alu_control_o
);

    always_comb begin
        alu_control_o = ALUCTL_ADD;
        case (alu_op_i)
            AOP_SUB:   alu_control_o = ALUCTL_SUB;
            AOP_FUNCT: begin
                // Unrecognised funct falls back to add; writeback still happens.
                case (funct_i)
                    FN_ADD:  alu_control_o = ALUCTL_ADD;
                    FN_SUB:  alu_control_o = ALUCTL_SUB;
                    FN_AND:  alu_control_o = ALUCTL_AND;
                    FN_OR:   alu_control_o = ALUCTL_OR;
                    FN_SLT:  alu_control_o = ALUCTL_SLT;
                    default: alu_control_o = ALUCTL_ADD;
                endcase
            end
            default:   alu_control_o = ALUCTL_ADD;
        endcase
    end

endmodule

// File: rtl/mips_control_fsm.sv
// Multi-cycle MIPS main control: Moore FSM, one state per cycle, strobes registered
// alongside the state so reset forces FETCH values asynchronously.
module mips_control_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int OPCODE_WIDTH = 6,
    parameter int FUNCT_WIDTH  = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic [FUNCT_WIDTH-1:0]  funct,
    input  logic                    zero,
    output logic                    mem_write,
    output logic                    ir_write,
    output logic                    reg_write,
    output logic                    pc_en,
    output logic                    iord,
    output logic                    mem_to_reg,
    output logic                    reg_dst,
    output logic                    alu_src_a,
    output logic [1:0]              alu_src_b,
    output logic [1:0]              pc_src,
    output logic [2:0]              alu_control,
    output logic [3:0]              state_o
);

    state_t state_q, state_d;
    ctrl_t  ctrl_q;

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = RTYPEEX;
                    OP_BEQ:       state_d = BEQEX;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JEX;
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR:  state_d = (opcode == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   state_d = MEMWB;
            RTYPEEX: state_d = RTYPEWB;
            ADDIEX:  state_d = ADDIWB;
            default: state_d = FETCH;
        endcase
    end

    // Strobes are precomputed from the next state so they are glitch-free flops
    // that still present pure Moore behaviour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            ctrl_q  <= state_ctrl(FETCH);
        end else begin
            state_q <= state_d;
            ctrl_q  <= state_ctrl(state_d);
        end
    end

    alu_decoder u_alu_decoder (
        .alu_op_i      (ctrl_q.alu_op),
        .funct_i       (funct),
        .alu_control_o (alu_control)
    );

    assign mem_write  = ctrl_q.mem_write;
    assign ir_write   = ctrl_q.ir_write;
    assign reg_write  = ctrl_q.reg_write;
    assign pc_en      = ctrl_q.pc_write | (ctrl_q.branch & zero);
    assign iord       = ctrl_q.iord;
    assign mem_to_reg = ctrl_q.mem_to_reg;
    assign reg_dst    = ctrl_q.reg_dst;
    assign alu_src_a  = ctrl_q.alu_src_a;
    assign alu_src_b  = ctrl_q.alu_src_b;
    assign pc_src     = ctrl_q.pc_src;
    assign state_o    = state_q;

endmodule

// File: tb/tb_mips_control_fsm.sv
// Scoreboard bench for mips_control_fsm: stimulus queues the expected per-cycle
// outputs, a monitor compares them on the falling edge.
module tb_mips_control_fsm;

    localparam logic [3:0] S_FETCH = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,
                           S_MEMRD = 4'd3,  S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,
                           S_RX    = 4'd6,  S_RW     = 4'd7,  S_BEQ    = 4'd8,
                           S_AX    = 4'd9,  S_AW     = 4'd10, S_JEX    = 4'd11;

    typedef struct packed {
        logic [3:0] st;
        logic       mw, irw, rw, pce, iord, m2r, rdst, asa;
        logic [1:0] asb, psrc;
        logic [2:0] aluc;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode, funct;
    logic       zero;
    logic       mem_write, ir_write, reg_write, pc_en, iord, mem_to_reg, reg_dst, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_control;
    logic [3:0] state_o;

    obs_t   obs;
    obs_t   exp_q[$];
    string  lbl_q[$];
    int     checks = 0;
    int     errors = 0;
    event   sample_ev;

    always #5 clk = ~clk;

    mips_control_fsm #(.OPCODE_WIDTH(6), .FUNCT_WIDTH(6)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
        .pc_en(pc_en), .iord(iord), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
        .alu_control(alu_control), .state_o(state_o)
    );

    assign obs = {state_o, mem_write, ir_write, reg_write, pc_en, iord, mem_to_reg,
                  reg_dst, alu_src_a, alu_src_b, pc_src, alu_control};

    // Expected outputs for one cycle, written out state by state.
    function automatic obs_t exp_of(input logic [3:0] s, input logic z, input logic [2:0] rx_alu);
        obs_t e;
        e      = '0;
        e.st   = s;
        e.aluc = 3'b010;
        case (s)
            S_FETCH:  begin e.irw = 1; e.pce = 1; e.asb = 2'b01; end
            S_DECODE: e.asb = 2'b11;
            S_MEMADR: begin e.asa = 1; e.asb = 2'b10; end
            S_MEMRD:  e.iord = 1;
            S_MEMWB:  begin e.rw = 1; e.m2r = 1; end
            S_MEMWR:  begin e.iord = 1; e.mw = 1; end
            S_RX:     begin e.asa = 1; e.aluc = rx_alu; end
            S_RW:     begin e.rw = 1; e.rdst = 1; end
            S_BEQ:    begin e.asa = 1; e.aluc = 3'b110; e.psrc = 2'b01; e.pce = z; end
            S_AX:     begin e.asa = 1; e.asb = 2'b10; end
            S_AW:     e.rw = 1;
            S_JEX:    begin e.psrc = 2'b10; e.pce = 1; end
            default:  e.st = s;
        endcase
        return e;
    endfunction

    task automatic push(input obs_t e, input string l);
        exp_q.push_back(e);
        lbl_q.push_back(l);
    endtask

    // Called just after a rising edge with the DUT in FETCH; n cycles are checked.
    task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input logic [2:0] rx_alu, input int n,
                             input logic [3:0] s0, input logic [3:0] s1, input logic [3:0] s2,
                             input logic [3:0] s3, input logic [3:0] s4);
        logic [3:0] seq [5];
        seq = '{s0, s1, s2, s3, s4};
        for (int i = 0; i < n; i++) begin
            opcode = op;
            funct  = fn;
            zero   = z;
            push(exp_of(seq[i], z, rx_alu), $sformatf("%s_c%0d", name, i));
            @(posedge clk);
            #1;
        end
    endtask

    initial begin : monitor
        obs_t  e;
        string l;
        forever begin
            @(negedge clk or sample_ev);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                l = lbl_q.pop_front();
                checks++;
                if (obs !== e) begin
                    errors++;
                    $display("FAIL %s: got %h want %h", l, obs, e);
                end
            end
        end
    end

    initial begin : stim
        obs_t rst_exp;
        rst_exp = exp_of(S_FETCH, 1'b0, 3'b010);
        rst_n  = 1'b0;
        opcode = 6'h00;
        funct  = 6'h00;
        zero   = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            push(rst_exp, $sformatf("reset_c%0d", i));
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;

        run_instr("lw",      6'b100011, 6'h00,     1'b0, 3'b010, 5, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB);
        run_instr("sw",      6'b101011, 6'h00,     1'b1, 3'b010, 4, S_FETCH, S_DECODE, S_MEMADR, S_MEMWR, S_FETCH);
        run_instr("slt",     6'b000000, 6'b101010, 1'b0, 3'b111, 4, S_FETCH, S_DECODE, S_RX, S_RW, S_FETCH);
        run_instr("sub",     6'b000000, 6'b100010, 1'b1, 3'b110, 4, S_FETCH, S_DECODE, S_RX, S_RW, S_FETCH);
        run_instr("and",     6'b000000, 6'b100100, 1'b0, 3'b000, 4, S_FETCH, S_DECODE, S_RX, S_RW, S_FETCH);
        run_instr("or",      6'b000000, 6'b100101, 1'b0, 3'b001, 4, S_FETCH, S_DECODE, S_RX, S_RW, S_FETCH);
        run_instr("add",     6'b000000, 6'b100000, 1'b0, 3'b010, 4, S_FETCH, S_DECODE, S_RX, S_RW, S_FETCH);
        run_instr("badfn",   6'b000000, 6'b000111, 1'b0, 3'b010, 4, S_FETCH, S_DECODE, S_RX, S_RW, S_FETCH);
        run_instr("addi",    6'b001000, 6'h15,     1'b1, 3'b010, 4, S_FETCH, S_DECODE, S_AX, S_AW, S_FETCH);
        run_instr("beq_t",   6'b000100, 6'h00,     1'b1, 3'b010, 3, S_FETCH, S_DECODE, S_BEQ, S_FETCH, S_FETCH);
        run_instr("beq_nt",  6'b000100, 6'h00,     1'b0, 3'b010, 3, S_FETCH, S_DECODE, S_BEQ, S_FETCH, S_FETCH);
        run_instr("j",       6'b000010, 6'h00,     1'b0, 3'b010, 3, S_FETCH, S_DECODE, S_JEX, S_FETCH, S_FETCH);
        run_instr("badop",   6'b111111, 6'h20,     1'b1, 3'b010, 2, S_FETCH, S_DECODE, S_FETCH, S_FETCH, S_FETCH);

        // lw aborted by reset while in MEMWB: strobes must drop before the next edge.
        run_instr("lw_ab",   6'b100011, 6'h00,     1'b0, 3'b010, 4, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_FETCH);
        push(exp_of(S_MEMWB, 1'b0, 3'b010), "lw_ab_memwb");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        push(rst_exp, "abort_async");
        -> sample_ev;
        @(posedge clk);
        #1;
        push(rst_exp, "abort_held");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_instr("j_post",  6'b000010, 6'h00,     1'b0, 3'b010, 3, S_FETCH, S_DECODE, S_JEX, S_FETCH, S_FETCH);
        push(exp_of(S_FETCH, 1'b0, 3'b010), "final_fetch");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
